// File: rtl/fp_posit_acc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fp_posit_acc_ctrl
// Description : Job sequencer for the fixed-point/posit accumulator datapath.
//               Fetches product terms, issues each to the datapath with a
//               start/done handshake, keeps the running accumulator, returns
//               the final sum on a valid/ready port and flags a datapath that
//               never completes via a watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_posit_acc_ctrl #(
    parameter int ACC_W   = 32,
    parameter int MAN_W   = 14,
    parameter int EXP_W   = 5,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    // job request
    input  logic             job_start,
    input  logic [LEN_W-1:0] job_len,
    input  logic [EXP_W-1:0] job_exp_set,
    // term stream
    input  logic             term_valid,
    output logic             term_ready,
    input  logic             term_sign,
    input  logic [EXP_W-1:0] term_exp,
    input  logic [MAN_W-1:0] term_fixed,
    // datapath issue
    output logic             acc_start,
    output logic             acc_sign,
    output logic [EXP_W-1:0] acc_exp_in,
    output logic [MAN_W-1:0] acc_fixed_in,
    output logic [EXP_W-1:0] acc_exp_set,
    output logic [ACC_W-1:0] acc_fixed_acc,
    input  logic             acc_done,
    input  logic [ACC_W-1:0] acc_fixed_out,
    // result
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_fixed,
    output logic [EXP_W-1:0] res_exp,
    output logic             res_err,
    output logic             busy
);

    // Watchdog sized to hold TIMEOUT so saturation is representable.
    localparam int WD_W = $clog2(TIMEOUT + 1);

    // The counter reads 0 in the first WAIT cycle, so WAIT cycle k holds k-1.
    // Leaving on TIMEOUT-2 puts the DONE entry exactly TIMEOUT cycles after
    // the ISSUE cycle.
    localparam logic [WD_W-1:0]  c_WD_LAST  = WD_W'(TIMEOUT - 2);
    localparam logic [WD_W-1:0]  c_WD_MAX   = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0]  c_WD_ZERO  = '0;
    localparam logic [LEN_W-1:0] c_REM_LAST = LEN_W'(1);
    localparam logic [LEN_W-1:0] c_REM_ZERO = '0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           r_state;
    logic [LEN_W-1:0] r_rem;
    logic [WD_W-1:0]  r_wd;
    logic [ACC_W-1:0] r_acc;
    logic [EXP_W-1:0] r_exp_set;
    logic             r_term_ready;
    logic             r_acc_start;
    logic             r_sign;
    logic [EXP_W-1:0] r_exp_in;
    logic [MAN_W-1:0] r_fixed_in;
    logic             r_res_valid;
    logic             r_res_err;
    logic             r_busy;

    // Sequencer: state, counters, accumulator and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rem        <= c_REM_ZERO;
            r_wd         <= c_WD_ZERO;
            r_acc        <= '0;
            r_exp_set    <= '0;
            r_term_ready <= 1'b0;
            r_acc_start  <= 1'b0;
            r_sign       <= 1'b0;
            r_exp_in     <= '0;
            r_fixed_in   <= '0;
            r_res_valid  <= 1'b0;
            r_res_err    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (job_start) begin
                        r_rem     <= job_len;
                        r_exp_set <= job_exp_set;
                        r_acc     <= '0;
                        r_res_err <= 1'b0;
                        r_busy    <= 1'b1;
                        if (job_len == c_REM_ZERO) begin
                            r_state     <= S_DONE;
                            r_res_valid <= 1'b1;
                        end else begin
                            r_state      <= S_FETCH;
                            r_term_ready <= 1'b1;
                        end
                    end
                end

                S_FETCH: begin
                    if (term_valid) begin
                        r_sign       <= term_sign;
                        r_exp_in     <= term_exp;
                        r_fixed_in   <= term_fixed;
                        r_term_ready <= 1'b0;
                        r_acc_start  <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    r_acc_start <= 1'b0;
                    r_wd        <= c_WD_ZERO;
                    r_state     <= S_WAIT;
                end

                S_WAIT: begin
                    if (r_wd != c_WD_MAX) begin
                        r_wd <= r_wd + 1'b1;
                    end
                    // A zero counter marks the first WAIT cycle, where done
                    // still reflects the previous term and must be ignored.
                    if (acc_done && (r_wd != c_WD_ZERO)) begin
                        r_acc <= acc_fixed_out;
                        r_rem <= r_rem - 1'b1;
                        if (r_rem == c_REM_LAST) begin
                            r_state     <= S_DONE;
                            r_res_valid <= 1'b1;
                        end else begin
                            r_state      <= S_FETCH;
                            r_term_ready <= 1'b1;
                        end
                    end else if (r_wd >= c_WD_LAST) begin
                        r_res_err   <= 1'b1;
                        r_res_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_res_err   <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state      <= S_IDLE;
                    r_term_ready <= 1'b0;
                    r_acc_start  <= 1'b0;
                    r_res_valid  <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign term_ready    = r_term_ready;
    assign acc_start     = r_acc_start;
    assign acc_sign      = r_sign;
    assign acc_exp_in    = r_exp_in;
    assign acc_fixed_in  = r_fixed_in;
    assign acc_exp_set   = r_exp_set;
    assign acc_fixed_acc = r_acc;
    assign res_valid     = r_res_valid;
    assign res_fixed     = r_acc;
    assign res_exp       = r_exp_set;
    assign res_err       = r_res_err;
    assign busy          = r_busy;

endmodule
`default_nettype wire
